// File: rtl/pipe_ctrl_pkg.sv
// ==========================================================================
// pipe_ctrl_pkg : opcodes, FSM state and forwarding-select types for pipe_ctrl
// Rev 1.0
// ==========================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Unlisted opcodes are treated as reading rs1 so a hazard is never missed.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: used = 1'b0;
      OP_R, OP_I, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JALR, OP_SYSTEM: used = 1'b1;
      default: used = 1'b1;
    endcase
    return used;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_unit.sv
// ==========================================================================
// fwd_unit : EX operand forwarding select for one source register
// Rev 1.0
// ==========================================================================
`default_nettype none

module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output fwd_sel_e          sel
);

  // EX/MEM is younger than MEM/WB, so it wins when both match.
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd == ex_rs) && (mem_rd != '0)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd == ex_rs) && (wb_rd != '0)) begin
      sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ==========================================================================
// pipe_ctrl : 5-stage pipeline stall/flush/forward controller.
// Optional performance counters under `PIPE_CTRL_PERF_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   id_inst,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
  output logic [31:0]       load_use_count
`endif
);

  state_e            state;
  state_e            next_state;
  fwd_sel_e          fwd_a;
  fwd_sel_e          fwd_b;
  logic [6:0]        id_opcode;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              load_use;
  logic              is_system;
  logic              mem_stall;
  logic              lu_bubble;
  logic              unused_id_bits;

  assign id_opcode      = id_inst[6:0];
  assign id_rs1         = id_inst[19:15];
  assign id_rs2         = id_inst[24:20];
  assign unused_id_bits = ^{id_inst[XLEN-1:25], id_inst[14:7]};

  assign load_use = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                    ((uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                     (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));
  assign is_system = (id_opcode == OP_SYSTEM);

  // Once waiting, only dmem_ready releases the freeze.
  assign mem_stall = (state == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b)
  );

  assign fwd_a_sel = rst ? FWD_RF : fwd_a;
  assign fwd_b_sel = rst ? FWD_RF : fwd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // The MEM_WAIT release cycle re-runs the RUN priority chain, so a redirect
  // held in the frozen EX stage is applied there.
  always_comb begin
    next_state = state;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_stall)        next_state = MEM_WAIT;
        else if (ex_redirect) next_state = RUN;
        else if (load_use)    next_state = RUN;
        else if (is_system)   next_state = HALT;
        else                  next_state = RUN;
      end
      HALT: begin
        if (!(dmem_req && !dmem_ready) && resume) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    lu_bubble   = 1'b0;
    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if (mem_stall) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            lu_bubble   = 1'b1;
          end else if (is_system) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        HALT: begin
          halted = 1'b1;
          if (dmem_req && !dmem_ready) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
          end else if (resume) begin
            // Retire the ECALL/EBREAK held in ID instead of executing it.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      flush_count    <= '0;
      load_use_count <= '0;
    end else begin
      if (!pc_en)      stall_cycles   <= stall_cycles + 32'd1;
      if (if_id_flush) flush_count    <= flush_count + 32'd1;
      if (lu_bubble)   load_use_count <= load_use_count + 32'd1;
    end
  end
`else
  logic unused_lu_bubble;
  assign unused_lu_bubble = lu_bubble;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ==========================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_reg_write, ex_is_load, mem_reg_write, wb_reg_write;
  logic        ex_redirect, dmem_req, dmem_ready, resume;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, halted;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count, load_use_count;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, halted}
  logic [7:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, halted};

  localparam logic [7:0] C_RESET  = 8'b00000000;
  localparam logic [7:0] C_RUN    = 8'b11111000;
  localparam logic [7:0] C_FREEZE = 8'b00000000;
  localparam logic [7:0] C_REDIR  = 8'b11111110;
  localparam logic [7:0] C_BUBBLE = 8'b00111010;
  localparam logic [7:0] C_HALT   = 8'b00111011;
  localparam logic [7:0] C_HFRZ   = 8'b00000001;
  localparam logic [7:0] C_RESUME = 8'b11111111;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [31:0] ADD_X7   = {7'd0, 5'd2, 5'd7, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] ADD_X0   = {7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] LUI_X7   = {20'h00038, 5'd7, 7'b0110111};
  localparam logic [31:0] SW_X7    = {7'd0, 5'd7, 5'd3, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] ADDI_I7  = {12'd7, 5'd3, 3'd0, 5'd1, 7'b0010011};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(32), .REG_AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_inst       (id_inst),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_is_load    (ex_is_load),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .ex_redirect   (ex_redirect),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .resume        (resume),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .halted        (halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count),
    .load_use_count (load_use_count)
`endif
  );

  task automatic idle();
    id_inst = NOP;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_reg_write = 0; ex_is_load = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_redirect = 0; dmem_req = 0; dmem_ready = 0; resume = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    mem_reg_write = 1; mem_rd = 5; ex_rs1 = 5; ex_rs2 = 5;
    #12;
    checks++;
    if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); end
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
    end
    cyc(); rst = 1'b0; idle(); #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_forwarding();
    cyc(); idle();
    mem_rd = 5; wb_rd = 5; ex_rs1 = 5; ex_rs2 = 6; mem_reg_write = 1; wb_reg_write = 1; #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin
      errors++; $display("FAIL fwd_mem_priority got=%b exp=0100", {fwd_a_sel, fwd_b_sel});
    end
    mem_reg_write = 0; #1;
    checks++;
    if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL fwd_wb got=%b exp=10", fwd_a_sel); end
    mem_rd = 0; wb_rd = 0; ex_rs1 = 0; mem_reg_write = 1; wb_reg_write = 1; #1;
    checks++;
    if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fwd_x0 got=%b exp=00", fwd_a_sel); end
    ex_rs1 = 3; ex_rs2 = 9; mem_rd = 9; wb_rd = 3; #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1001) begin
      errors++; $display("FAIL fwd_split got=%b exp=1001", {fwd_a_sel, fwd_b_sel});
    end
    mem_reg_write = 0; wb_rd = 9; #1;
    checks++;
    if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL fwd_b_wb got=%b exp=10", fwd_b_sel); end
  endtask

  task automatic test_load_use();
    cyc(); idle();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_inst = ADD_X7; #1;
    checks++;
    if (ctl !== C_BUBBLE) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_BUBBLE); end
    cyc(); ex_is_load = 0; ex_reg_write = 0; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL lu_after got=%b exp=%b", ctl, C_RUN); end
    cyc(); ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_inst = LUI_X7; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL lu_lui got=%b exp=%b", ctl, C_RUN); end
    id_inst = SW_X7; #1;
    checks++;
    if (ctl !== C_BUBBLE) begin errors++; $display("FAIL lu_store_rs2 got=%b exp=%b", ctl, C_BUBBLE); end
    id_inst = ADDI_I7; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL lu_itype_rs2 got=%b exp=%b", ctl, C_RUN); end
    id_inst = ADD_X0; ex_rd = 0; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_RUN); end
    id_inst = ADD_X7; ex_rd = 7; ex_reg_write = 0; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL lu_nowrite got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_redirect_priority();
    cyc(); idle();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_inst = ADD_X7; ex_redirect = 1; #1;
    checks++;
    if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_over_lu got=%b exp=%b", ctl, C_REDIR); end
    cyc(); idle(); #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL redir_after got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_dmem_wait();
    cyc(); idle(); dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) cyc();
      #1;
      checks++;
      if (ctl !== C_FREEZE) begin errors++; $display("FAIL dmem_freeze%0d got=%b exp=%b", i, ctl, C_FREEZE); end
    end
    cyc(); dmem_ready = 1; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL dmem_release got=%b exp=%b", ctl, C_RUN); end
    cyc(); dmem_req = 0; dmem_ready = 0; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL dmem_back_run got=%b exp=%b", ctl, C_RUN); end
    cyc(); dmem_req = 1; ex_redirect = 1; #1;
    checks++;
    if (ctl !== C_FREEZE) begin errors++; $display("FAIL dmem_over_redir got=%b exp=%b", ctl, C_FREEZE); end
    cyc(); dmem_ready = 1; #1;
    checks++;
    if (ctl !== C_REDIR) begin errors++; $display("FAIL dmem_release_redir got=%b exp=%b", ctl, C_REDIR); end
    cyc(); idle(); #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL dmem_redir_after got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_halt();
    cyc(); idle(); id_inst = ECALL; #1;
    checks++;
    if (ctl !== C_BUBBLE) begin errors++; $display("FAIL halt_enter got=%b exp=%b", ctl, C_BUBBLE); end
    cyc(); #1;
    checks++;
    if (ctl !== C_HALT) begin errors++; $display("FAIL halt_state got=%b exp=%b", ctl, C_HALT); end
    cyc(); dmem_req = 1; #1;
    checks++;
    if (ctl !== C_HFRZ) begin errors++; $display("FAIL halt_dmem got=%b exp=%b", ctl, C_HFRZ); end
    cyc(); dmem_req = 0; #1;
    checks++;
    if (ctl !== C_HALT) begin errors++; $display("FAIL halt_stay got=%b exp=%b", ctl, C_HALT); end
    cyc(); resume = 1; #1;
    checks++;
    if (ctl !== C_RESUME) begin errors++; $display("FAIL halt_resume got=%b exp=%b", ctl, C_RESUME); end
    cyc(); resume = 0; id_inst = NOP; #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL halt_exit got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_reset_midwait();
    cyc(); idle(); dmem_req = 1; #1;
    cyc(); dmem_req = 0; #1;
    checks++;
    if (ctl !== C_FREEZE) begin errors++; $display("FAIL mw_in_wait got=%b exp=%b", ctl, C_FREEZE); end
    mem_reg_write = 1; mem_rd = 4; ex_rs1 = 4; ex_rs2 = 4;
    rst = 1; #1;
    checks++;
    if ({ctl, fwd_a_sel, fwd_b_sel} !== 12'h000) begin
      errors++; $display("FAIL mw_reset_outs got=%b exp=%b", {ctl, fwd_a_sel, fwd_b_sel}, 12'h000);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if ({stall_cycles, flush_count, load_use_count} !== 96'd0) begin
      errors++; $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", stall_cycles, flush_count, load_use_count);
    end
`endif
    #1 rst = 0; idle(); #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL mw_async_run got=%b exp=%b", ctl, C_RUN); end
`ifdef PIPE_CTRL_PERF_EN
    cyc(); dmem_req = 1;
    cyc(); cyc();
    cyc(); dmem_ready = 1;
    cyc(); idle(); #1;
    checks++;
    if (stall_cycles !== 32'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles); end
    ex_redirect = 1;
    cyc(); idle(); #1;
    checks++;
    if ({flush_count, load_use_count} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL perf_flush got=%0d/%0d exp=1/0", flush_count, load_use_count);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_priority();
    test_dmem_wait();
    test_halt();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
